// File: rtl/mmcm_drp_sequencer.sv
// DRP read-modify-write sequencer for an MMCME2_ADV: holds the MMCM in reset across a command
// burst, then releases it and waits for LOCKED. Define MMCM_DRP_READBACK_EN to verify every write.
module mmcm_drp_sequencer #(
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int DRDY_TIMEOUT = 255,
    parameter int CNT_W        = 21
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [6:0]  cmd_addr_i,
    input  logic [15:0] cmd_mask_i,
    input  logic [15:0] cmd_data_i,
    input  logic        cmd_last_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [6:0]  mmcm_daddr_o,
    output logic [15:0] mmcm_di_o,
    output logic        mmcm_den_o,
    output logic        mmcm_dwe_o,
    input  logic [15:0] mmcm_do_i,
    input  logic        mmcm_drdy_i,
    output logic        mmcm_rst_o,
    input  logic        mmcm_locked_i
);

`ifdef MMCM_DRP_READBACK_EN
    typedef enum logic [3:0] {
        S_IDLE, S_RST_ON, S_CMD, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT,
        S_VFY_REQ, S_VFY_WAIT, S_RELEASE, S_LOCK, S_ABORT
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_RST_ON, S_CMD, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT,
        S_RELEASE, S_LOCK, S_ABORT
    } state_t;
`endif

    // Timeouts fire on the cycle the counter would reach the limit.
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DRDY = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;
`ifdef MMCM_DRP_READBACK_EN
    localparam logic [1:0] ERR_VFY  = 2'd3;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [6:0]        r_addr;
    logic [15:0]       r_mask;
    logic [15:0]       r_data;
    logic              r_last;
    logic [15:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic              r_mmcm_rst;

    logic              w_busy_next;
    logic              w_done_next;
    logic              w_err_next;
    logic [1:0]        w_err_code_next;
    logic              w_mmcm_rst_next;
    logic              w_ready;
    logic              w_den;
    logic              w_dwe;
    logic              w_drdy_to;
    logic              w_lock_to;
    logic [15:0]       w_wdata;

    assign w_drdy_to = (r_cnt == DRDY_LAST);
    assign w_lock_to = (r_cnt == LOCK_LAST);
    assign w_wdata   = (mmcm_do_i & r_mask) | (r_data & ~r_mask);

    always_comb begin
        w_state_next    = r_state;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;
        w_err_code_next = r_err_code;
        w_mmcm_rst_next = r_mmcm_rst;
        w_ready         = 1'b0;
        w_den           = 1'b0;
        w_dwe           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_state_next    = S_RST_ON;
                    w_busy_next     = 1'b1;
                    w_err_code_next = ERR_NONE;
                end
            end
            S_RST_ON: begin
                w_mmcm_rst_next = 1'b1;
                w_state_next    = S_CMD;
            end
            S_CMD: begin
                w_ready = 1'b1;
                if (cmd_valid_i) begin
                    w_state_next = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                w_den        = 1'b1;
                w_state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mmcm_drdy_i) begin
                    w_state_next = S_WR_REQ;
                end else if (w_drdy_to) begin
                    w_state_next    = S_ABORT;
                    w_err_next      = 1'b1;
                    w_err_code_next = ERR_DRDY;
                end
            end
            S_WR_REQ: begin
                w_den        = 1'b1;
                w_dwe        = 1'b1;
                w_state_next = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (mmcm_drdy_i) begin
`ifdef MMCM_DRP_READBACK_EN
                    w_state_next = S_VFY_REQ;
`else
                    w_state_next = r_last ? S_RELEASE : S_CMD;
`endif
                end else if (w_drdy_to) begin
                    w_state_next    = S_ABORT;
                    w_err_next      = 1'b1;
                    w_err_code_next = ERR_DRDY;
                end
            end
`ifdef MMCM_DRP_READBACK_EN
            S_VFY_REQ: begin
                w_den        = 1'b1;
                w_state_next = S_VFY_WAIT;
            end
            S_VFY_WAIT: begin
                if (mmcm_drdy_i) begin
                    if (mmcm_do_i != r_wdata) begin
                        w_state_next    = S_ABORT;
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_VFY;
                    end else begin
                        w_state_next = r_last ? S_RELEASE : S_CMD;
                    end
                end else if (w_drdy_to) begin
                    w_state_next    = S_ABORT;
                    w_err_next      = 1'b1;
                    w_err_code_next = ERR_DRDY;
                end
            end
`endif
            S_RELEASE: begin
                w_mmcm_rst_next = 1'b0;
                w_state_next    = S_LOCK;
            end
            S_LOCK: begin
                if (mmcm_locked_i) begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end else if (w_lock_to) begin
                    w_state_next    = S_IDLE;
                    w_busy_next     = 1'b0;
                    w_err_next      = 1'b1;
                    w_err_code_next = ERR_LOCK;
                    w_mmcm_rst_next = 1'b0;
                end
            end
            S_ABORT: begin
                w_mmcm_rst_next = 1'b0;
                w_busy_next     = 1'b0;
                w_state_next    = S_IDLE;
            end
            default: begin
                w_state_next    = S_IDLE;
                w_busy_next     = 1'b0;
                w_mmcm_rst_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_mask     <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_mmcm_rst <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            // Every state change restarts the shared timeout counter.
            r_cnt      <= (w_state_next != r_state) ? '0 : r_cnt + 1'b1;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_err_code <= w_err_code_next;
            r_mmcm_rst <= w_mmcm_rst_next;
            if (r_state == S_CMD && cmd_valid_i) begin
                r_addr <= cmd_addr_i;
                r_mask <= cmd_mask_i;
                r_data <= cmd_data_i;
                r_last <= cmd_last_i;
            end
            if (r_state == S_RD_WAIT && mmcm_drdy_i) begin
                r_wdata <= w_wdata;
            end
        end
    end

    assign cmd_ready_o  = w_ready;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign err_code_o   = r_err_code;
    assign mmcm_daddr_o = r_addr;
    assign mmcm_di_o    = r_wdata;
    assign mmcm_den_o   = w_den;
    assign mmcm_dwe_o   = w_dwe;
    assign mmcm_rst_o   = r_mmcm_rst;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Scoreboard bench for mmcm_drp_sequencer: a DRP/MMCM model plus a shadow register map predicts
// every DRP access and the outcome of each sequence.
module tb_mmcm_drp_sequencer;
    localparam int LOCK_TO = 1000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [6:0]  cmd_addr_i = '0;
    logic [15:0] cmd_mask_i = '0;
    logic [15:0] cmd_data_i = '0;
    logic        cmd_last_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [6:0]  mmcm_daddr_o;
    logic [15:0] mmcm_di_o;
    logic        mmcm_den_o, mmcm_dwe_o;
    logic [15:0] mmcm_do_i = '0;
    logic        mmcm_drdy_i = 1'b0;
    logic        mmcm_rst_o;
    logic        mmcm_locked_i = 1'b0;

    mmcm_drp_sequencer #(.LOCK_TIMEOUT(LOCK_TO), .DRDY_TIMEOUT(255), .CNT_W(21)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_mask_i(cmd_mask_i), .cmd_data_i(cmd_data_i),
        .cmd_last_i(cmd_last_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .mmcm_daddr_o(mmcm_daddr_o), .mmcm_di_o(mmcm_di_o),
        .mmcm_den_o(mmcm_den_o), .mmcm_dwe_o(mmcm_dwe_o),
        .mmcm_do_i(mmcm_do_i), .mmcm_drdy_i(mmcm_drdy_i),
        .mmcm_rst_o(mmcm_rst_o), .mmcm_locked_i(mmcm_locked_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  addr;
        logic        we;
        logic [15:0] di;
    } op_t;

    op_t         exp_ops[$];
    int          exp_out[$];
    logic [15:0] mem[128];
    logic [15:0] shadow[128];
    logic [6:0]  c_addr[4];
    logic [15:0] c_mask[4];
    logic [15:0] c_data[4];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int outcomes_seen = 0;
    int last_den_cyc = 0;
    int drdy_fixed = 0;
    int lock_delay = 5;
    bit sup_first_read = 0;
    bit corrupt = 0;
    bit lock_low = 0;

    // model state
    int          pend = 0;
    logic [15:0] pend_do = '0;
    logic [6:0]  last_wa = '0;
    bit          just_wrote = 0;
    int          lcnt = 0;
    int          stale = 0;
    logic        m_prev_rst = 1'b0;
    logic        prev_mrst = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // DRP slave and MMCM lock behaviour; LOCKED lingers a few cycles after RST rises.
    always @(negedge clk) begin
        mmcm_drdy_i = 1'b0;
        if (rst_i) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mmcm_drdy_i = 1'b1;
                    mmcm_do_i   = pend_do;
                end
            end
            if (mmcm_den_o) begin
                if (mmcm_dwe_o) begin
                    mem[mmcm_daddr_o] = mmcm_di_o;
                    pend_do    = 16'($urandom);
                    just_wrote = 1;
                    last_wa    = mmcm_daddr_o;
                end else begin
                    pend_do = mem[mmcm_daddr_o];
                    if (corrupt && just_wrote && mmcm_daddr_o == last_wa) pend_do[0] = ~pend_do[0];
                    just_wrote = 0;
                end
                if (sup_first_read && !mmcm_dwe_o) begin
                    sup_first_read = 0;
                    pend = 0;
                end else begin
                    pend = (drdy_fixed > 0) ? drdy_fixed : int'($urandom_range(1, 4));
                end
            end
        end
        if (mmcm_rst_o) begin
            if (!m_prev_rst) stale = 3;
            if (stale > 0) stale--;
            else mmcm_locked_i = 1'b0;
            lcnt = 0;
        end else if (lock_low) begin
            mmcm_locked_i = 1'b0;
        end else if (lcnt >= lock_delay) begin
            mmcm_locked_i = 1'b1;
        end else begin
            lcnt++;
        end
        m_prev_rst = mmcm_rst_o;
    end

    // Monitor: pops the scoreboard whenever the DUT issues a DRP access or ends a sequence.
    always @(negedge clk) begin
        op_t e;
        int act;
        cyc++;
        if (!rst_i && mmcm_den_o) begin
            last_den_cyc = cyc;
            if (exp_ops.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_den got addr=%0h we=%0b exp none", mmcm_daddr_o, mmcm_dwe_o);
            end else begin
                e = exp_ops.pop_front();
                chk("drp_addr", 32'(mmcm_daddr_o), 32'(e.addr));
                chk("drp_we", 32'(mmcm_dwe_o), 32'(e.we));
                if (e.we) chk("drp_di", 32'(mmcm_di_o), 32'(e.di));
                chk("rst_held", 32'(mmcm_rst_o), 32'd1);
            end
        end
        if (!rst_i && prev_mrst && !mmcm_rst_o) chk("rst_fall_ops_left", exp_ops.size(), 0);
        prev_mrst = mmcm_rst_o;
        if (!rst_i && (done_o || err_o)) begin
            act = (done_o && !err_o) ? 0 : (err_o && !done_o) ? int'(err_code_o) : 99;
            outcomes_seen++;
            if (exp_out.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_outcome got=%0d exp none", act);
            end else begin
                chk("outcome", act, exp_out.pop_front());
            end
            if (done_o) chk("busy_at_done", 32'(busy_o), 32'd0);
            if (err_o && err_code_o == 2'd1) chk("drdy_to_latency", cyc - last_den_cyc, 256);
        end
    end

    task automatic rand_cmds(input int n);
        for (int i = 0; i < n; i++) begin
            c_addr[i] = 7'($urandom);
            c_mask[i] = 16'($urandom);
            c_data[i] = 16'($urandom);
        end
    endtask

    // Predict the accesses from the shadow map, then drive the commands until an outcome appears.
    task automatic run_seq(input int n, input int exp_code);
        int idx = 0;
        int budget = 0;
        int start;
        int exp_consumed;
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            exp_ops.push_back('{addr: c_addr[i], we: 1'b0, di: 16'h0});
            if (exp_code == 1) break;
            w = (shadow[c_addr[i]] & c_mask[i]) | (c_data[i] & ~c_mask[i]);
            shadow[c_addr[i]] = w;
            exp_ops.push_back('{addr: c_addr[i], we: 1'b1, di: w});
`ifdef MMCM_DRP_READBACK_EN
            exp_ops.push_back('{addr: c_addr[i], we: 1'b0, di: 16'h0});
`endif
            if (exp_code == 3) break;
        end
        exp_out.push_back(exp_code);
        exp_consumed = (exp_code == 1 || exp_code == 3) ? 1 : n;
        start = outcomes_seen;
        @(negedge clk);
        cmd_addr_i  = c_addr[0];
        cmd_mask_i  = c_mask[0];
        cmd_data_i  = c_data[0];
        cmd_last_i  = (n == 1);
        cmd_valid_i = 1'b1;
        while (outcomes_seen == start && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (cmd_valid_i && cmd_ready_o) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < n) begin
                    cmd_addr_i = c_addr[idx];
                    cmd_mask_i = c_mask[idx];
                    cmd_data_i = c_data[idx];
                    cmd_last_i = (idx == n - 1);
                end else begin
                    cmd_valid_i = 1'b0;
                end
            end
        end
        cmd_valid_i = 1'b0;
        if (outcomes_seen == start) begin
            tests++;
            fails++;
            $display("FAIL seq_timeout got no outcome exp code %0d", exp_code);
        end
        repeat (3) @(negedge clk);
        chk("cmds_consumed", idx, exp_consumed);
        chk("ops_drained", exp_ops.size(), 0);
        chk("outcomes_drained", exp_out.size(), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 128; i++) begin
            mem[i]    = 16'($urandom);
            shadow[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_flags", {30'd0, done_o, err_o}, 32'd0);
        chk("rst_code", 32'(err_code_o), 32'd0);
        chk("rst_drp", {7'd0, mmcm_den_o, mmcm_dwe_o, mmcm_daddr_o, mmcm_di_o}, 32'd0);
        chk("rst_mmcm_rst", 32'(mmcm_rst_o), 32'd0);
        rst_i = 1'b0;

        // directed single command
        mem[8] = 16'hFFFF;
        shadow[8] = 16'hFFFF;
        c_addr[0] = 7'h08;
        c_mask[0] = 16'h1000;
        c_data[0] = 16'h0145;
        drdy_fixed = 2;
        run_seq(1, 0);
        chk("directed_mem", 32'(mem[8]), 32'h1145);
        drdy_fixed = 0;

        rand_cmds(3);
        run_seq(3, 0);

        repeat (8) begin
            n = int'($urandom_range(1, 4));
            lock_delay = int'($urandom_range(0, 20));
            rand_cmds(n);
            run_seq(n, 0);
        end
        lock_delay = 5;

        // DRDY never returned on the first read
        rand_cmds(2);
        sup_first_read = 1;
        run_seq(2, 1);
        chk("drdy_to_code_held", 32'(err_code_o), 32'd1);
        chk("drdy_to_rst_low", 32'(mmcm_rst_o), 32'd0);

        // LOCKED never rises
        rand_cmds(1);
        lock_low = 1;
        run_seq(1, 2);
        chk("lock_to_code_held", 32'(err_code_o), 32'd2);
        lock_low = 0;

        // asynchronous reset while waiting on the write DRDY
        rand_cmds(1);
        exp_ops.push_back('{addr: c_addr[0], we: 1'b0, di: 16'h0});
        shadow[c_addr[0]] = (shadow[c_addr[0]] & c_mask[0]) | (c_data[0] & ~c_mask[0]);
        exp_ops.push_back('{addr: c_addr[0], we: 1'b1, di: shadow[c_addr[0]]});
        drdy_fixed = 30;
        @(negedge clk);
        cmd_addr_i  = c_addr[0];
        cmd_mask_i  = c_mask[0];
        cmd_data_i  = c_data[0];
        cmd_last_i  = 1'b1;
        cmd_valid_i = 1'b1;
        begin
            int b = 0;
            bit seen = 0;
            while (!seen && b < 200) begin
                @(negedge clk);
                b++;
                if (mmcm_den_o && mmcm_dwe_o) seen = 1;
                if (cmd_valid_i && cmd_ready_o) begin
                    @(posedge clk);
                    #1;
                    cmd_valid_i = 1'b0;
                end
            end
            chk("write_issued", 32'(seen), 32'd1);
        end
        cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        pend = 0;
        #1;
        chk("mid_rst_den", 32'(mmcm_den_o), 32'd0);
        chk("mid_rst_mmcm_rst", 32'(mmcm_rst_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        exp_ops.delete();
        exp_out.delete();
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        drdy_fixed = 0;
        rand_cmds(2);
        run_seq(2, 0);

        // bit 0 corrupted on readback
        corrupt = 1;
        just_wrote = 0;
        rand_cmds(1);
`ifdef MMCM_DRP_READBACK_EN
        run_seq(1, 3);
        chk("vfy_code_held", 32'(err_code_o), 32'd3);
`else
        run_seq(1, 0);
`endif
        corrupt = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
